// File: rtl/regfile_port_arbiter_pkg.sv
// regfile_port_arbiter_pkg
//  Shared definitions for the register file port arbiter slice: the
//  default bus widths and the arbiter FSM state encoding.
package regfile_port_arbiter_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int NUM_REGS_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if
//  One requester's valid/ready bus into the register file arbiter.
//  master : requester side (drives valid/we/addr/wdata, sees ready/rvalid/rdata)
//  slave  : arbiter side
//  valid  request valid, held until ready
//  we     1=write, 0=read
//  addr   register address
//  wdata  write data
//  ready  request granted this cycle
//  rvalid read data valid, one-cycle pulse after a read grant
//  rdata  read data
interface regfile_port_arbiter_if
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
//  Two-way round-robin arbiter.
//  req      {req1, req0}
//  rr_ptr   index preferred when both request
//  gnt      one-hot grant (zero when nobody requests)
//  next_ptr pointer to load after this cycle: the non-granted index, or
//           the current pointer when there is no grant
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt,
  output logic       next_ptr
);

  // A lone requester always wins; a tie goes to the pointer, and the
  // pointer then moves to the loser so neither side can be starved.
  always_comb begin
    gnt      = req;
    next_ptr = rr_ptr;
    if (req == 2'b11) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
    if (gnt[0]) begin
      next_ptr = 1'b1;
    end else if (gnt[1]) begin
      next_ptr = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//  Shares the register file's single write/read-A port between core
//  writeback (m0) and the loader/debug port (m1), and owns the clear
//  sequencer that zeroes every register one per cycle.
//  clk        rising-edge clock
//  reset_n    asynchronous active-low reset
//  m0, m1     requester buses (slave side)
//  clear_req  request a full register clear (sampled in RUN only)
//  busy       high while the clear sweep runs
//  rf_load    register file write enable
//  rf_addr_a  register file port A address
//  rf_d_in    register file write data
//  rf_val_a   register file port A read data (combinational)
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NUM_REGS       = NUM_REGS_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_port_arbiter_if.slave m0,
  regfile_port_arbiter_if.slave m1,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  rf_load,
  output logic [ADDR_W-1:0]     rf_addr_a,
  output logic [DATA_W-1:0]     rf_d_in,
  input  logic [DATA_W-1:0]     rf_val_a
);

  localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);
  localparam arb_state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;
  logic              rr_ptr;
  logic              rr_ptr_next;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              rd_gnt0;
  logic              rd_gnt1;

  // Requests only reach the arbiter in RUN with no clear pending and
  // reset released, so the grant vector is already the final ready.
  assign req = {m1.valid, m0.valid} & {2{reset_n && (state == ST_RUN) && !clear_req}};

  rr_arbiter2 u_rr_arbiter2 (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .gnt      (gnt),
    .next_ptr (rr_ptr_next)
  );

  assign rd_gnt0 = gnt[0] && !m0.we;
  assign rd_gnt1 = gnt[1] && !m1.we;

  // Next-state and register file port mux. The sweep drives the port
  // with zeros at clr_cnt; in RUN the granted requester owns it, and an
  // idle port is parked at address 0 with no load.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    busy         = 1'b0;
    rf_load      = 1'b0;
    rf_addr_a    = '0;
    rf_d_in      = '0;
    m0.ready     = gnt[0];
    m1.ready     = gnt[1];
    case (state)
      ST_CLEAR: begin
        busy      = reset_n;
        rf_load   = reset_n;
        rf_addr_a = clr_cnt;
        if (clr_cnt == LAST_REG) begin
          clr_cnt_next = '0;
          state_next   = ST_RUN;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
        end
        if (gnt[0]) begin
          rf_load   = m0.we;
          rf_addr_a = m0.addr;
          rf_d_in   = m0.we ? m0.wdata : '0;
        end else if (gnt[1]) begin
          rf_load   = m1.we;
          rf_addr_a = m1.addr;
          rf_d_in   = m1.we ? m1.wdata : '0;
        end
      end
    endcase
  end

  // State, sweep counter, fairness pointer and read-return registers.
  // Read data is captured from the combinational port on the grant edge
  // and held until that requester's next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      rr_ptr    <= 1'b0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      rr_ptr    <= rr_ptr_next;
      m0.rvalid <= rd_gnt0;
      m1.rvalid <= rd_gnt1;
      if (rd_gnt0) begin
        m0.rdata <= rf_val_a;
      end
      if (rd_gnt1) begin
        m1.rdata <= rf_val_a;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
//  Directed bench for regfile_port_arbiter with a behavioural 8x8
//  register file on the rf_* port. Inputs change 1 ns after the rising
//  edge; outputs are sampled on the falling edge.
module tb_regfile_port_arbiter;

  logic       clk;
  logic       reset_n;
  logic       clear_req;
  logic       busy;
  logic       rf_load;
  logic [2:0] rf_addr_a;
  logic [7:0] rf_d_in;
  logic [7:0] rf_val_a;
  logic [7:0] rf_mem [8];

  int tests_run;
  int tests_failed;

  regfile_port_arbiter_if #(.DATA_W(8), .ADDR_W(3)) m0_bus ();
  regfile_port_arbiter_if #(.DATA_W(8), .ADDR_W(3)) m1_bus ();

  regfile_port_arbiter #(
    .DATA_W         (8),
    .ADDR_W         (3),
    .NUM_REGS       (8),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .clear_req (clear_req),
    .busy      (busy),
    .rf_load   (rf_load),
    .rf_addr_a (rf_addr_a),
    .rf_d_in   (rf_d_in),
    .rf_val_a  (rf_val_a)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_load) begin
      rf_mem[rf_addr_a] <= rf_d_in;
    end
  end
  assign rf_val_a = rf_mem[rf_addr_a];

  // A requester may not drop valid while its request is still waiting.
  logic m0_pend;
  logic m1_pend;
  always @(posedge clk) begin
    if (reset_n && m0_pend) begin
      assert (m0_bus.valid) else $error("[TB] m0 withdrew valid before ready");
    end
    if (reset_n && m1_pend) begin
      assert (m1_bus.valid) else $error("[TB] m1 withdrew valid before ready");
    end
    m0_pend <= reset_n && m0_bus.valid && !m0_bus.ready;
    m1_pend <= reset_n && m1_bus.valid && !m1_bus.ready;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [2:0] a0,
                               input logic [7:0] d0, input logic v1, input logic we1,
                               input logic [2:0] a1, input logic [7:0] d1,
                               input logic clr);
    tick();
    m0_bus.valid = v0;
    m0_bus.we    = we0;
    m0_bus.addr  = a0;
    m0_bus.wdata = d0;
    m1_bus.valid = v1;
    m1_bus.we    = we1;
    m1_bus.addr  = a1;
    m1_bus.wdata = d1;
    clear_req    = clr;
  endtask

  // Caller has just entered sweep cycle 0; checks all eight sweep cycles.
  task automatic checkSweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_load"}, 32'(rf_load), 32'd1);
      checkOutput({tag, "_addr"}, 32'(rf_addr_a), 32'(i));
      checkOutput({tag, "_din"}, 32'(rf_d_in), 32'd0);
      checkOutput({tag, "_rdy0"}, 32'(m0_bus.ready), 32'd0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    clear_req    = 1'b0;
    m0_bus.valid = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.valid = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;

    // 1. reset values, then the power-on sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_load", 32'(rf_load), 32'd0);
    checkOutput("rst_rvalid0", 32'(m0_bus.rvalid), 32'd0);
    checkOutput("rst_rdata1", 32'(m1_bus.rdata), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    checkSweep("sweep1");
    tick();
    @(negedge clk);
    checkOutput("post_sweep_busy", 32'(busy), 32'd0);
    checkOutput("post_sweep_load", 32'(rf_load), 32'd0);
    checkOutput("post_sweep_addr", 32'(rf_addr_a), 32'd0);

    // 2. m0 write r3=A5, read r3 back, then fill r1/r2/r7
    applyStimulus(1, 1, 3'd3, 8'hA5, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("wr3_ready", 32'(m0_bus.ready), 32'd1);
    checkOutput("wr3_load", 32'(rf_load), 32'd1);
    checkOutput("wr3_addr", 32'(rf_addr_a), 32'd3);
    checkOutput("wr3_din", 32'(rf_d_in), 32'hA5);
    applyStimulus(1, 0, 3'd3, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("rd3_ready", 32'(m0_bus.ready), 32'd1);
    checkOutput("rd3_load", 32'(rf_load), 32'd0);
    checkOutput("rd3_addr", 32'(rf_addr_a), 32'd3);
    applyStimulus(1, 1, 3'd1, 8'h11, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("rd3_rvalid", 32'(m0_bus.rvalid), 32'd1);
    checkOutput("rd3_rdata", 32'(m0_bus.rdata), 32'hA5);
    checkOutput("wr1_din", 32'(rf_d_in), 32'h11);
    applyStimulus(1, 1, 3'd2, 8'h22, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("wr2_rvalid_drop", 32'(m0_bus.rvalid), 32'd0);
    checkOutput("wr2_addr", 32'(rf_addr_a), 32'd2);
    applyStimulus(1, 1, 3'd7, 8'h77, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("wr7_din", 32'(rf_d_in), 32'h77);

    // 4. m1 streams reads of r1, r2, r7 (pointer ends at 0)
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd1, 8'h00, 0);
    @(negedge clk);
    checkOutput("m1rd1_ready", 32'(m1_bus.ready), 32'd1);
    checkOutput("m1rd1_addr", 32'(rf_addr_a), 32'd1);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd2, 8'h00, 0);
    @(negedge clk);
    checkOutput("m1rd2_ready", 32'(m1_bus.ready), 32'd1);
    checkOutput("m1rd1_rvalid", 32'(m1_bus.rvalid), 32'd1);
    checkOutput("m1rd1_rdata", 32'(m1_bus.rdata), 32'h11);
    checkOutput("m1rd1_m0rvalid", 32'(m0_bus.rvalid), 32'd0);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd7, 8'h00, 0);
    @(negedge clk);
    checkOutput("m1rd7_ready", 32'(m1_bus.ready), 32'd1);
    checkOutput("m1rd2_rvalid", 32'(m1_bus.rvalid), 32'd1);
    checkOutput("m1rd2_rdata", 32'(m1_bus.rdata), 32'h22);
    checkOutput("m1rd2_m0rvalid", 32'(m0_bus.rvalid), 32'd0);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("m1rd7_rvalid", 32'(m1_bus.rvalid), 32'd1);
    checkOutput("m1rd7_rdata", 32'(m1_bus.rdata), 32'h77);
    checkOutput("m1rd7_m0rvalid", 32'(m0_bus.rvalid), 32'd0);
    checkOutput("m1_idle_ready", 32'(m1_bus.ready), 32'd0);

    // 3. both write continuously: m0, m1, m0, m1
    applyStimulus(1, 1, 3'd4, 8'h40, 1, 1, 3'd6, 8'h61, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      checkOutput("rr_ready0", 32'(m0_bus.ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_ready1", 32'(m1_bus.ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("rr_din", 32'(rf_d_in), (k % 2 == 0) ? 32'h40 : 32'h61);
      checkOutput("rr_addr", 32'(rf_addr_a), (k % 2 == 0) ? 32'd4 : 32'd6);
    end

    // 5. clear_req while m0 wants to write r5=3C
    applyStimulus(1, 1, 3'd5, 8'h3C, 0, 0, 3'd0, 8'h00, 1);
    @(negedge clk);
    checkOutput("clr_req_ready0", 32'(m0_bus.ready), 32'd0);
    checkOutput("clr_req_load", 32'(rf_load), 32'd0);
    checkOutput("clr_req_busy", 32'(busy), 32'd0);
    tick();
    clear_req = 1'b0;
    checkSweep("sweep2");
    tick();
    @(negedge clk);
    checkOutput("wr5_ready", 32'(m0_bus.ready), 32'd1);
    checkOutput("wr5_addr", 32'(rf_addr_a), 32'd5);
    checkOutput("wr5_din", 32'(rf_d_in), 32'h3C);
    checkOutput("wr5_busy", 32'(busy), 32'd0);
    applyStimulus(1, 0, 3'd5, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("rd5_ready", 32'(m0_bus.ready), 32'd1);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd4, 8'h00, 0);
    @(negedge clk);
    checkOutput("rd5_rdata", 32'(m0_bus.rdata), 32'h3C);
    checkOutput("rd5_rvalid", 32'(m0_bus.rvalid), 32'd1);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("rd4_cleared", 32'(m1_bus.rdata), 32'h00);

    // 6. reset in the middle of a sweep
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 1);
    @(negedge clk);
    checkOutput("clr3_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
      @(negedge clk);
      checkOutput("sweep3_addr", 32'(rf_addr_a), 32'(i));
    end
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_load", 32'(rf_load), 32'd0);
    checkOutput("midrst_rdata0", 32'(m0_bus.rdata), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    checkSweep("sweep4");
    tick();
    @(negedge clk);
    checkOutput("post_sweep4_busy", 32'(busy), 32'd0);

    // pointer is back at m0 after reset
    applyStimulus(1, 0, 3'd5, 8'h00, 1, 0, 3'd3, 8'h00, 0);
    @(negedge clk);
    checkOutput("ptr_rst_ready0", 32'(m0_bus.ready), 32'd1);
    checkOutput("ptr_rst_ready1", 32'(m1_bus.ready), 32'd0);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd3, 8'h00, 0);
    @(negedge clk);
    checkOutput("ptr_next_ready1", 32'(m1_bus.ready), 32'd1);
    applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk);
    checkOutput("ptr_next_rvalid1", 32'(m1_bus.rvalid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
